// File: rtl/srt_div_pkg.sv
// srt_div_pkg: shared types and constants for the shared SRT divider scheduler
package srt_div_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  localparam int DATA_W = 32;
  localparam int REM_W = 33;
  localparam logic [DATA_W-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
endpackage

// File: rtl/srt_32bit.sv
// srt_32bit: combinational 32-bit divider, inputs dividend_i/divisor_i, outputs quotient_o/remainder_o (33b)
module srt_32bit (
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [32:0] remainder_o
);
  always_comb begin
    quotient_o = (divisor_i == '0) ? '1 : dividend_i / divisor_i;
    remainder_o = (divisor_i == '0) ? {1'b0, dividend_i} : {1'b0, dividend_i % divisor_i};
  end
endmodule

// File: rtl/srt_div_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req_i/ptr_i in, one-hot grant_o and encoded idx_o out
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o
);
  logic found;
  int j;
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    j = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[j]) begin
        found = 1'b1;
        idx_o = ID_W'(j);
      end
    end
    grant_o = found ? NUM_REQ'(1) << idx_o : '0;
  end
endmodule

// File: rtl/srt_div_scheduler.sv
// srt_div_scheduler: shares one srt_32bit divider between NUM_REQ requesters, one op in flight
//   req_valid_i/req_ready_o/req_dividend_i/req_divisor_i: per-requester request side (32b slices)
//   rsp_valid_o/rsp_ready_i/rsp_id_o/rsp_quotient_o/rsp_remainder_o/rsp_div_by_zero_o: response side
module srt_div_scheduler
  import srt_div_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SETTLE_CYCLES = 3,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*32-1:0]   req_dividend_i,
  input  logic [NUM_REQ*32-1:0]   req_divisor_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [DATA_W-1:0]       rsp_quotient_o,
  output logic [REM_W-1:0]        rsp_remainder_o,
  output logic                    rsp_div_by_zero_o
);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  state_e state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d, gnt_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] dvd_q, dvd_d, dvs_q, dvs_d, quo_q, quo_d, div_quo, sel_dvd, sel_dvs;
  logic [REM_W-1:0] rem_q, rem_d, div_rem;
  logic dz_q, dz_d, accept;
  logic [NUM_REQ-1:0] gnt;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i  (req_valid_i & {NUM_REQ{state_q == IDLE}}),
    .ptr_i  (rr_ptr_q),
    .grant_o(gnt),
    .idx_o  (gnt_idx)
  );
  // divider sees only the operand registers, so its path is a SETTLE_CYCLES multicycle path
  srt_32bit u_div (
    .dividend_i (dvd_q),
    .divisor_i  (dvs_q),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );
  assign req_ready_o = gnt;
  assign accept = |gnt;
  assign sel_dvd = req_dividend_i[32*gnt_idx +: 32];
  assign sel_dvs = req_divisor_i[32*gnt_idx +: 32];
  assign rsp_valid_o = state_q == RESP;
  assign rsp_id_o = id_q;
  assign rsp_quotient_o = quo_q;
  assign rsp_remainder_o = rem_q;
  assign rsp_div_by_zero_o = dz_q;
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d = id_q;
    cnt_d = cnt_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dz_d = dz_q;
    case (state_q)
      IDLE: if (accept) begin
        dvd_d = sel_dvd;
        dvs_d = sel_dvs;
        id_d = gnt_idx;
        rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        if (sel_dvs == '0) begin
          quo_d = DIV0_QUOTIENT;
          rem_d = {1'b0, sel_dvd};
          dz_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = CNT_W'(SETTLE_CYCLES - 1);
          state_d = ISSUE;
        end
      end
      ISSUE: if (cnt_q == '0) begin
        quo_d = div_quo;
        rem_d = div_rem;
        dz_d = 1'b0;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      RESP: state_d = rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      id_q <= '0;
      cnt_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dz_q <= dz_d;
    end
  end
endmodule
